// File: rtl/imem_loader.sv
// Boot loader: frames a little-endian byte stream into 32-bit instruction-memory writes,
// holding the CPU in reset until the whole image has landed.
module imem_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded
);

  // S_LAST covers the cycle of the final write pulse, so done rises right after it.
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_LAST, S_DONE, S_ERR} state_t;

  localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     CAPACITY  = 32'd1 << ADDR_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [15:0]           r_len;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_buf;
  logic [TW-1:0]         r_idle;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [15:0]           r_words_loaded;

  logic                  w_loading;
  logic                  w_accept;
  logic                  w_timeout;
  logic                  w_last_word;
  logic [15:0]           w_len_full;

  assign w_loading   = (r_state == S_LEN1) || (r_state == S_DATA);
  assign in_ready    = !rst && ((r_state == S_LEN0) || w_loading);
  assign w_accept    = in_valid && in_ready;
  assign w_len_full  = {in_data, r_len[7:0]};
  assign w_last_word = (r_byte_idx == 2'd3) && ((r_words_loaded + 16'd1) == r_len);
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_loading && !w_accept && (r_idle == IDLE_LAST);

  assign imem_we      = r_we && !rst;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_rst      = rst || (r_state != S_DONE);
  assign done         = (r_state == S_DONE);
  assign err          = (r_state == S_ERR);
  assign words_loaded = r_words_loaded;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LEN0;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LEN0: if (w_accept) w_state_next = S_LEN1;
      S_LEN1: begin
        if (w_accept) begin
          if ((w_len_full == 16'd0) || ({16'd0, w_len_full} > CAPACITY)) w_state_next = S_ERR;
          else                                                              w_state_next = S_DATA;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_DATA: begin
        if (w_accept && w_last_word) w_state_next = S_LAST;
        else if (w_timeout)          w_state_next = S_ERR;
      end
      S_LAST:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_DONE;
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_LEN0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len          <= '0;
      r_byte_idx     <= '0;
      r_buf          <= '0;
      r_idle         <= '0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_words_loaded <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        r_idle <= '0;
        case (r_state)
          S_LEN0: r_len[7:0]  <= in_data;
          S_LEN1: r_len[15:8] <= in_data;
          S_DATA: begin
            if (r_byte_idx == 2'd3) begin
              r_we           <= 1'b1;
              r_addr         <= r_words_loaded[ADDR_WIDTH-1:0];
              r_wdata        <= {in_data, r_buf};
              r_words_loaded <= r_words_loaded + 16'd1;
              r_byte_idx     <= 2'd0;
            end else begin
              // Shift right so the first byte ends up in the least significant lane.
              r_buf      <= {in_data, r_buf[23:8]};
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
          default: ;
        endcase
      end else if (w_loading) begin
        r_idle <= r_idle + TW'(1);
      end
    end
  end

endmodule
